fpga_arduino_tx: RTL and testbench

Transmits 16-bit command words from the FPGA to the Arduino controller over three GPIO header output lines: serial clock, serial data and frame strobe. The Arduino returns one acknowledge line. It is the return-direction counterpart of arduino_fpga_comm and carries game feedback (score, streak and haptic codes) back to the controller. Upstream logic, such as hardware_software_comm or a to_hw_port, loads words through a valid/ready handshake.

---
 rtl/fpga_arduino_tx.sv | 211 +++++++++++++++++++++
 tb/tb_fpga_arduino_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_arduino_tx.sv
// fpga_arduino_tx
// ---------------
// Sends command words from the FPGA to the Arduino over three GPIO lines
// (serial clock, serial data, frame strobe). After each frame it waits for a
// rising edge on the Arduino's acknowledge line. Each bit is presented MSB
// first, with sdata held stable across the whole low/high sclk pair, and the
// Arduino samples on the rising edge of sclk. Every phase (start, each half
// bit, stop, each timeout step) lasts one baud tick of CLK_DIV clk cycles.
//
// Optional build macro: PARITY_EN. When defined, one even-parity bit (XOR of
// the payload) is appended after the last data bit.
//
// Parameters:
//   CLK_DIV      clk cycles per baud tick (>= 2)
//   DATA_W       payload bits per frame
//   ACK_TIMEOUT  baud ticks to wait for the acknowledge (>= 1)
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   tx_data      word to send, latched on acceptance
//   tx_valid     upstream has a word
//   tx_ready     high only while idle; accept = tx_valid & tx_ready
//   gpio_sclk    serial clock to the Arduino
//   gpio_sdata   serial data to the Arduino
//   gpio_frame   high for the duration of a frame
//   gpio_ack     acknowledge from the Arduino (asynchronous)
//   tx_done      one-cycle pulse when an acknowledge is received
//   err_timeout  sticky: the last frame was not acknowledged
module fpga_arduino_tx #(
  parameter int CLK_DIV     = 250,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              gpio_sclk,
  output logic              gpio_sdata,
  output logic              gpio_frame,
  input  logic              gpio_ack,
  output logic              tx_done,
  output logic              err_timeout
);

`ifdef PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    SHIFT    = 3'd2,
    STOP     = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  state_t           state;
  logic [CW-1:0]    baud_cnt;
  logic             baud_tick;
  logic [BW-1:0]    bit_cnt;
  logic             high_phase;
  logic [AW-1:0]    ack_cnt;
  logic [NBITS-2:0] rest;       // bits still to be sent after the one on gpio_sdata
  logic [NBITS-1:0] load_bits;
  logic             ack_meta;
  logic             ack_sync;
  logic             ack_prev;
  logic             ack_rise;
  logic             accept;

  // Payload as it goes on the wire, with the parity bit appended when enabled.
  function automatic logic [NBITS-1:0] frame_bits(input logic [DATA_W-1:0] d);
`ifdef PARITY_EN
    frame_bits = {d, ^d};
`else
    frame_bits = d;
`endif
  endfunction

  assign load_bits = frame_bits(tx_data);
  // tx_ready is high exactly in IDLE, so it doubles as the idle qualifier.
  assign accept    = tx_valid && tx_ready;
  assign baud_tick = (baud_cnt == BAUD_LAST);
  // Rising edge of the synchronized acknowledge; a level that is already high
  // produces no edge, so a stale acknowledge can never complete a frame.
  assign ack_rise  = ack_sync && !ack_prev;

  // Two-flop synchronizer for the asynchronous acknowledge plus an edge-detect flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_meta <= gpio_ack;
      ack_sync <= ack_meta;
      ack_prev <= ack_sync;
    end
  end

  // Baud divider: restarted on acceptance so every frame is phase-aligned to it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      baud_cnt <= {CW{1'b0}};
    end else if (accept || baud_tick) begin
      baud_cnt <= {CW{1'b0}};
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  // Frame sequencer with registered line outputs and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      gpio_sclk   <= 1'b0;
      gpio_sdata  <= 1'b0;
      gpio_frame  <= 1'b0;
      tx_done     <= 1'b0;
      err_timeout <= 1'b0;
      bit_cnt     <= {BW{1'b0}};
      high_phase  <= 1'b0;
      ack_cnt     <= {AW{1'b0}};
      rest        <= {(NBITS-1){1'b0}};
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            gpio_sdata <= load_bits[NBITS-1];
            rest       <= load_bits[NBITS-2:0];
            gpio_frame <= 1'b1;
            gpio_sclk  <= 1'b0;
            tx_ready   <= 1'b0;
            bit_cnt    <= {BW{1'b0}};
            high_phase <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (baud_tick) begin
            if (!high_phase) begin
              high_phase <= 1'b1;
              gpio_sclk  <= 1'b1;
            end else begin
              high_phase <= 1'b0;
              gpio_sclk  <= 1'b0;
              rest       <= rest << 1;
              if (bit_cnt == BIT_LAST) begin
                gpio_frame <= 1'b0;
                gpio_sdata <= 1'b0;
                state      <= STOP;
              end else begin
                bit_cnt    <= bit_cnt + BW'(1);
                gpio_sdata <= rest[NBITS-2];
              end
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            ack_cnt <= {AW{1'b0}};
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // An acknowledge wins over a timeout landing on the same cycle.
          if (ack_rise) begin
            tx_done     <= 1'b1;
            err_timeout <= 1'b0;
            tx_ready    <= 1'b1;
            state       <= IDLE;
          end else if (baud_tick) begin
            if (ack_cnt == ACK_LAST) begin
              err_timeout <= 1'b1;
              tx_ready    <= 1'b1;
              state       <= IDLE;
            end else begin
              ack_cnt <= ack_cnt + AW'(1);
            end
          end
        end
        default: begin
          gpio_sclk  <= 1'b0;
          gpio_sdata <= 1'b0;
          gpio_frame <= 1'b0;
          tx_ready   <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_arduino_tx.sv
// Self-checking bench for fpga_arduino_tx (default build, CLK_DIV=4,
// DATA_W=16, ACK_TIMEOUT=8). A timeline model predicts every output on every
// cycle from the acceptance cycle and the sampled acknowledge history; a
// line monitor recovers the transmitted word on sclk rising edges and the
// frame/timeout timing for the hand-computed checks.
module tb_fpga_arduino_tx;
  localparam int CLK_DIV     = 4;
  localparam int DATA_W      = 16;
  localparam int ACK_TIMEOUT = 8;
  // Cycles after acceptance at which WAIT_ACK starts and the timeout fires.
  localparam int KW = CLK_DIV * (2 * DATA_W + 2);
  localparam int KT = KW + ACK_TIMEOUT * CLK_DIV;

  logic              clk = 1'b1;
  logic              reset_n;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              gpio_sclk;
  logic              gpio_sdata;
  logic              gpio_frame;
  logic              gpio_ack;
  logic              tx_done;
  logic              err_timeout;

  int total = 0;
  int bad   = 0;

  // model state
  int          cyc  = 0;
  bit          busy = 1'b0;
  int          acc  = 0;
  logic [15:0] word = 16'h0000;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  bit          ack_at [0:16383];

  // monitor results
  logic [15:0] cap = 16'h0000;
  int          cap_n = 0;
  int          frame_len = 0;
  int          frame_len_last = 0;
  int          fall_cyc = 0;
  int          err_rise_cyc = 0;
  int          done_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_frame = 1'b0;
  logic        prev_err = 1'b0;

  fpga_arduino_tx #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .gpio_sclk(gpio_sclk), .gpio_sdata(gpio_sdata),
    .gpio_frame(gpio_frame), .gpio_ack(gpio_ack), .tx_done(tx_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model and compare process: at each negedge compare, then advance the model
  // over the coming edge using the inputs that edge will sample.
  initial begin
    int k, s, b;
    logic [5:0] ev;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        // {tx_ready, gpio_frame, gpio_sclk, gpio_sdata, tx_done, err_timeout}
        ev = {~busy, 3'b000, m_done, m_err};
        if (busy) begin
          k = cyc - acc;
          s = k / CLK_DIV;
          if (s == 0) begin
            ev[4:2] = {1'b1, 1'b0, word[DATA_W-1]};
          end else if (s <= 2 * DATA_W) begin
            b = (s - 1) / 2;
            ev[4] = 1'b1;
            ev[3] = ((s - 1) % 2) == 1;
            ev[2] = word[DATA_W-1-b];
          end
        end
        check("cycle_model", {26'd0, tx_ready, gpio_frame, gpio_sclk, gpio_sdata, tx_done, err_timeout},
              {26'd0, ev});
        // line monitor
        if (gpio_frame === 1'b1 && prev_frame === 1'b0) begin
          cap = 16'h0000; cap_n = 0; frame_len = 0;
        end
        if (gpio_frame === 1'b1) frame_len++;
        if (gpio_frame === 1'b0 && prev_frame === 1'b1) begin
          frame_len_last = frame_len; fall_cyc = cyc;
        end
        if (gpio_sclk === 1'b1 && prev_sclk === 1'b0) begin
          cap = {cap[14:0], gpio_sdata}; cap_n++;
        end
        if (tx_done === 1'b1) done_cnt++;
        if (err_timeout === 1'b1 && prev_err === 1'b0) err_rise_cyc = cyc;
        prev_frame = gpio_frame; prev_sclk = gpio_sclk; prev_err = err_timeout;
      end
      if (cyc < 16383) cyc++;
      ack_at[cyc] = reset_n & gpio_ack;
      m_done = 1'b0;
      if (!reset_n) begin
        busy = 1'b0; m_err = 1'b0;
      end else if (!busy) begin
        if (tx_valid) begin
          busy = 1'b1; acc = cyc; word = tx_data;
        end
      end else begin
        k = cyc - acc;
        // acknowledge = rising edge of the synchronized line while waiting
        if (cyc >= 3 && ack_at[cyc-2] && !ack_at[cyc-3] && (k - 1) >= KW && k <= KT) begin
          busy = 1'b0; m_done = 1'b1; m_err = 1'b0;
        end else if (k == KT) begin
          busy = 1'b0; m_err = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 1000 && tx_ready !== 1'b1; i++) step(1);
    check(nm, tx_ready, 1);
  endtask

  task automatic wait_frame_fall(input string nm);
    for (int i = 0; i < 1000 && gpio_frame !== 1'b0; i++) step(1);
    check(nm, gpio_frame, 0);
  endtask

  task automatic send(input logic [15:0] w);
    wait_ready("ready_before_send");
    tx_data  = w;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    gpio_ack = 1'b1;
    step(4);
    gpio_ack = 1'b0;
  endtask

  // Directed stimulus and hand-computed expectations.
  initial begin
    int d0;
    reset_n = 1'b0; tx_valid = 1'b1; tx_data = 16'hBEEF; gpio_ack = 1'b0;
    step(3);
    check("reset_state", {tx_ready, gpio_sclk, gpio_sdata, gpio_frame, tx_done, err_timeout}, 6'b100000);
    tx_valid = 1'b0; reset_n = 1'b1;
    step(2);
    check("no_accept_in_reset", {tx_ready, gpio_frame}, 2'b10);

    // basic frame, ack 10 cycles after STOP
    d0 = done_cnt;
    send(16'hA5C3);
    wait_frame_fall("basic_fall");
    step(10);
    ack_pulse();
    wait_ready("basic_ready");
    step(2);
    check("basic_bits", cap, 16'hA5C3);
    check("basic_nbits", cap_n, 16);
    check("basic_frame_len", frame_len_last, 132);
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_err", err_timeout, 0);

    // timeout: no acknowledge
    d0 = done_cnt;
    send(16'h0001);
    wait_frame_fall("to_fall");
    wait_ready("to_ready");
    step(2);
    check("to_err", err_timeout, 1);
    check("to_delay", err_rise_cyc - fall_cyc, CLK_DIV * (1 + ACK_TIMEOUT));
    check("to_no_done", done_cnt - d0, 0);
    check("to_bits", cap, 16'h0001);

    // acknowledged frame clears the sticky error
    send(16'h5A5A);
    check("err_sticky", err_timeout, 1);
    wait_frame_fall("clr_fall");
    step(6);
    ack_pulse();
    wait_ready("clr_ready");
    step(2);
    check("clr_err", err_timeout, 0);
    check("clr_bits", cap, 16'h5A5A);

    // busy: second word offered mid-shift is ignored
    send(16'h1234);
    step(40);
    tx_data = 16'hFFFF; tx_valid = 1'b1;
    step(1);
    check("busy_ready", tx_ready, 0);
    wait_frame_fall("busy_fall");
    tx_valid = 1'b0;
    step(6);
    ack_pulse();
    wait_ready("busy_done");
    step(20);
    check("busy_bits", cap, 16'h1234);
    check("busy_no_second", gpio_frame, 0);

    // early acknowledge: level high on entry to WAIT_ACK must not count
    d0 = done_cnt;
    send(16'h0F0F);
    step(20);
    gpio_ack = 1'b1;
    wait_frame_fall("early_fall");
    step(10);
    check("early_no_done", done_cnt - d0, 0);
    check("early_still_busy", tx_ready, 0);
    gpio_ack = 1'b0;
    step(3);
    gpio_ack = 1'b1;
    wait_ready("early_ready");
    step(2);
    gpio_ack = 1'b0;
    check("early_done", done_cnt - d0, 1);
    check("early_bits", cap, 16'h0F0F);

    // reset during bit 7 aborts the frame
    send(16'hC3C3);
    step(61);
    reset_n = 1'b0;
    step(1);
    check("midreset_idle", {tx_ready, gpio_sclk, gpio_sdata, gpio_frame, tx_done, err_timeout}, 6'b100000);
    reset_n = 1'b1;
    step(2);
    send(16'h00FF);
    wait_frame_fall("after_fall");
    step(6);
    ack_pulse();
    wait_ready("after_ready");
    step(2);
    check("after_bits", cap, 16'h00FF);
    check("after_nbits", cap_n, 16);
    check("after_len", frame_len_last, 132);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
